// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register sequencer: state encoding and
// a helper that sizes the bit-index counter from the word width.
package shift_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        GAP     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Inter-bit gap counter width; holds 0..15.
    localparam int GAP_CNT_W = 4;

    // Bits needed to index a WIDTH-bit word (never less than one).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts a word over valid/ready, feeds it LSB-first into a
// right-shift register (sr_din/sr_en), captures the register's parallel Q
// and offers it downstream over a second valid/ready handshake.
// Optional macro SHIFT_SEQ_CTRL_CHECK_EN adds a 'mismatch' output that flags
// a captured word differing from the word that was shifted in.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int BIT_GAP = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_din,
    output logic             sr_en,
    input  logic [WIDTH-1:0] sr_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
    output logic             mismatch,
`endif
    output logic             busy
);

    localparam int                   IW       = cnt_width(WIDTH);
    localparam logic [IW-1:0]        LAST_IDX = IW'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((BIT_GAP > 0) ? BIT_GAP - 1 : 0);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   sr_en_q, sr_en_d;
    logic                   sr_din_q, sr_din_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
    logic                   mismatch_q, mismatch_d;
`endif

    // Next-state, counters and the registered handshake/shift outputs.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        bit_idx_d  = bit_idx_q;
        gap_cnt_d  = gap_cnt_q;
        out_data_d = out_data_q;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    hold_d    = in_data;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx_q == LAST_IDX) begin
                    state_d = CAPTURE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (BIT_GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                // Last enabled edge has already happened, so sr_q is complete.
                out_data_d = sr_q;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
                mismatch_d = (sr_q != hold_q);
`endif
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state calls for;
        // sr_din keeps its last value outside SHIFT.
        sr_en_d     = (state_d == SHIFT);
        sr_din_d    = (state_d == SHIFT) ? hold_d[bit_idx_d] : sr_din_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            bit_idx_q   <= '0;
            gap_cnt_q   <= '0;
            sr_en_q     <= 1'b0;
            sr_din_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            sr_en_q     <= sr_en_d;
            sr_din_q    <= sr_din_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign sr_en     = sr_en_q;
    assign sr_din    = sr_din_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: three instances (W4/G0, W4/G2, W8/G0), each
// paired with a behavioural right-shift register as its datapath.
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;

    // W4, BIT_GAP=0
    logic       iv4, ir4, din4, en4, ov4, or4, busy4;
    logic [3:0] id4, q4reg, q4, od4, mask4;
    // W4, BIT_GAP=2
    logic       ivg, irg, ding, eng, ovg, org, busyg;
    logic [3:0] idg, qgreg, odg;
    // W8, BIT_GAP=0
    logic       iv8, ir8, din8, en8, ov8, or8, busy8;
    logic [7:0] id8, q8reg, od8;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
    logic       mm4, mmg, mm8;
`endif

    // mask4 lets a stuck-at-0 fault be planted on the Q bus of the W4 instance
    assign q4 = q4reg & mask4;

    always @(posedge clk or posedge clr) begin
        if (clr) q4reg <= '0;
        else if (en4) q4reg <= {din4, q4reg[3:1]};
    end
    always @(posedge clk or posedge clr) begin
        if (clr) qgreg <= '0;
        else if (eng) qgreg <= {ding, qgreg[3:1]};
    end
    always @(posedge clk or posedge clr) begin
        if (clr) q8reg <= '0;
        else if (en8) q8reg <= {din8, q8reg[7:1]};
    end

    shift_seq_ctrl #(.WIDTH(4), .BIT_GAP(0)) u4 (
        .clk(clk), .clr(clr), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .sr_din(din4), .sr_en(en4), .sr_q(q4), .out_valid(ov4), .out_ready(or4),
        .out_data(od4),
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
        .mismatch(mm4),
`endif
        .busy(busy4));

    shift_seq_ctrl #(.WIDTH(4), .BIT_GAP(2)) ug (
        .clk(clk), .clr(clr), .in_valid(ivg), .in_ready(irg), .in_data(idg),
        .sr_din(ding), .sr_en(eng), .sr_q(qgreg), .out_valid(ovg), .out_ready(org),
        .out_data(odg),
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
        .mismatch(mmg),
`endif
        .busy(busyg));

    shift_seq_ctrl #(.WIDTH(8), .BIT_GAP(0)) u8 (
        .clk(clk), .clr(clr), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .sr_din(din8), .sr_en(en8), .sr_q(q8reg), .out_valid(ov8), .out_ready(or8),
        .out_data(od8),
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
        .mismatch(mm8),
`endif
        .busy(busy8));

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic sel_ov(input int sel);
        return (sel == 0) ? ov4 : (sel == 1) ? ovg : ov8;
    endfunction

    // Ticks until out_valid of the selected instance is seen; n = ticks taken.
    task automatic wait_valid(input int sel, output int n);
        logic v;
        n = 0;
        v = sel_ov(sel);
        while (!v && n < 40) begin
            tick();
            n++;
            v = sel_ov(sel);
        end
        check("wait_valid", 32'(v), 32'd1);
    endtask

    logic [31:0] en_pat, ov_pat, din_pat;
    int          n, bad;

    initial begin
        clr = 1'b1; mask4 = 4'hF;
        iv4 = 0; or4 = 0; id4 = '0;
        ivg = 0; org = 0; idg = '0;
        iv8 = 0; or8 = 0; id8 = '0;
        tick(); tick();

        // Reset state while clr is held
        check("rst_in_ready",  32'(ir4),   32'd0);
        check("rst_busy",      32'(busy4), 32'd0);
        check("rst_sr_en",     32'(en4),   32'd0);
        check("rst_sr_din",    32'(din4),  32'd0);
        check("rst_out_valid", 32'(ov4),   32'd0);
        check("rst_out_data",  32'(od4),   32'd0);
        clr = 1'b0;
        tick();
        check("rel_in_ready4", 32'(ir4), 32'd1);
        check("rel_in_readyg", 32'(irg), 32'd1);
        check("rel_in_ready8", 32'(ir8), 32'd1);

        // Basic: W4 G0, 1001
        id4 = 4'b1001; iv4 = 1;
        tick();
        iv4 = 0;
        en_pat = 0; ov_pat = 0; din_pat = 0;
        for (int c = 0; c < 7; c++) begin
            en_pat = {en_pat[30:0], en4};
            ov_pat = {ov_pat[30:0], ov4};
            if (en4) din_pat = {din_pat[30:0], din4};
            tick();
        end
        check("basic_en_pat",  en_pat,  32'b1111000);
        check("basic_ov_pat",  ov_pat,  32'b0000011);
        check("basic_din_pat", din_pat, 32'b1001);
        check("basic_data",    32'(od4),  32'b1001);
        check("basic_in_rdy",  32'(ir4),  32'd0);
        check("basic_busy",    32'(busy4), 32'd1);
        or4 = 1;
        tick();
        or4 = 0;
        check("basic_ov_drop", 32'(ov4),   32'd0);
        check("basic_idle",    32'(busy4), 32'd0);
        check("basic_rdy_back", 32'(ir4),  32'd1);

        // Gap: W4 G2, 0110
        idg = 4'b0110; ivg = 1;
        tick();
        ivg = 0;
        en_pat = 0; ov_pat = 0; din_pat = 0;
        for (int c = 0; c < 13; c++) begin
            en_pat = {en_pat[30:0], eng};
            ov_pat = {ov_pat[30:0], ovg};
            if (eng) din_pat = {din_pat[30:0], ding};
            tick();
        end
        check("gap_en_pat",  en_pat,  32'b1001001001000);
        check("gap_ov_pat",  ov_pat,  32'b0000000000011);
        check("gap_din_pat", din_pat, 32'b0110);
        check("gap_data",    32'(odg), 32'b0110);

        // Backpressure: hold DONE for 5 cycles with a new word pending
        idg = 4'b0011; ivg = 1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!(ovg === 1'b1 && odg === 4'b0110 && irg === 1'b0 && busyg === 1'b1)) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        org = 1;
        tick();
        org = 0;
        check("bp_ov_drop", 32'(ovg),   32'd0);
        check("bp_idle",    32'(busyg), 32'd0);
        check("bp_in_rdy",  32'(irg),   32'd1);
        tick();
        ivg = 0;
        check("bp_accept",  32'(busyg), 32'd1);
        check("bp_rdy_low", 32'(irg),   32'd0);
        wait_valid(1, n);
        check("bp_latency", 32'(n),   32'd11);
        check("bp_data2",   32'(odg), 32'b0011);
        org = 1;
        tick();
        org = 0;

        // Reset mid-shift on W4
        id4 = 4'b1010; iv4 = 1;
        tick();
        iv4 = 0;
        tick(); tick();
        check("mid_sr_en_on", 32'(en4), 32'd1);
        clr = 1'b1;
        #1;
        check("mid_sr_en",  32'(en4),   32'd0);
        check("mid_busy",   32'(busy4), 32'd0);
        check("mid_ov",     32'(ov4),   32'd0);
        check("mid_in_rdy", 32'(ir4),   32'd0);
        tick();
        clr = 1'b0;
        tick();
        check("mid_rel_rdy", 32'(ir4), 32'd1);
        id4 = 4'b1111; iv4 = 1;
        tick();
        iv4 = 0;
        wait_valid(0, n);
        check("mid_latency", 32'(n),   32'd5);
        check("mid_data",    32'(od4), 32'b1111);
        or4 = 1;
        tick();
        or4 = 0;

        // Width sweep: W8, out_ready tied high
        or8 = 1; id8 = 8'hA5; iv8 = 1;
        tick();
        iv8 = 0;
        wait_valid(2, n);
        check("w8_latency", 32'(n),   32'd9);
        check("w8_data",    32'(od8), 32'hA5);
        tick();
        check("w8_busy",    32'(busy8), 32'd0);
        check("w8_ov_drop", 32'(ov8),   32'd0);
        or8 = 0;

`ifdef SHIFT_SEQ_CTRL_CHECK_EN
        // Stuck-at-0 on Q[2] must be flagged; clean wiring must not be
        mask4 = 4'b1011; id4 = 4'b0100; iv4 = 1;
        tick();
        iv4 = 0;
        wait_valid(0, n);
        check("chk_mm_set",   32'(mm4), 32'd1);
        check("chk_bad_data", 32'(od4), 32'b0000);
        or4 = 1;
        tick();
        or4 = 0;
        check("chk_mm_clr", 32'(mm4), 32'd0);
        mask4 = 4'hF; id4 = 4'b0100; iv4 = 1;
        tick();
        iv4 = 0;
        wait_valid(0, n);
        check("chk_mm_ok",   32'(mm4), 32'd0);
        check("chk_ok_data", 32'(od4), 32'b0100);
        or4 = 1;
        tick();
        or4 = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
